alu_issue_stage: RTL

Single-issue, multi-cycle operand/issue stage that sits directly upstream of `Alu_Top`. It accepts 32-bit MIPS instruction words over a valid/ready handshake and holds a 32×32 register file. It decodes the instruction, drives `Alu_Top`'s `opcode`/`func_field`/`A`/`B` from registers, and captures `result`/`zero`. It then writes back R-type results, emits load addresses, and resolves `beq`.

---
 rtl/alu_issue_stage_if.sv | 9 +
 rtl/alu_issue_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Instruction handshake between an upstream fetch/queue (master) and alu_issue_stage (slave).
interface alu_issue_stage_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;

  modport master (output in_valid, output in_instr, input  in_ready);
  modport slave  (input  in_valid, input  in_instr, output in_ready);
endinterface

// File: rtl/alu_issue_stage.sv
// Multi-cycle operand/issue stage for Alu_Top: decode, register read, ALU drive, write-back.
// Define ALU_ISSUE_PERF_EN to add the perf_retired / perf_illegal counters.
module alu_issue_stage #(
  parameter int NREGS = 32,
  parameter int W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_stage_if.slave in_if,
  output logic [5:0]       alu_opcode,
  output logic [5:0]       alu_func,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_zero,
  input  logic             ld_wr_en,
  input  logic [4:0]       ld_wr_addr,
  input  logic [W-1:0]     ld_wr_data,
  output logic             done,
  output logic             illegal,
  output logic             ld_req,
  output logic [W-1:0]     ld_addr,
  output logic [4:0]       ld_rt,
  output logic             br_taken,
  output logic [W-1:0]     br_offset
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_retired,
  output logic [15:0]      perf_illegal
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;
  typedef enum logic [1:0] {C_RTYPE, C_LW, C_BEQ, C_ILLEGAL} cls_e;

  state_e         state_q, state_d;
  cls_e           cls_q, cls_d;
  logic [31:0]    instr_q, instr_d;
  logic [5:0]     opcode_q, opcode_d;
  logic [5:0]     func_q, func_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           done_q, done_d;
  logic           illegal_q, illegal_d;
  logic           ld_req_q, ld_req_d;
  logic [W-1:0]   ld_addr_q, ld_addr_d;
  logic [4:0]     ld_rt_q, ld_rt_d;
  logic           br_taken_q, br_taken_d;
  logic [W-1:0]   br_offset_q, br_offset_d;
  logic [W-1:0]   rf_q [NREGS];
  logic [W-1:0]   rf_d [NREGS];
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]    perf_retired_q, perf_retired_d;
  logic [15:0]    perf_illegal_q, perf_illegal_d;
`endif

  // Instruction fields of the latched word.
  logic [5:0]     op_f, fn_f;
  logic [4:0]     rs_f, rt_f, rd_f;
  logic [W-1:0]   imm_sext;
  logic [W-1:0]   rs_val, rt_val;

  always_comb begin
    op_f     = instr_q[31:26];
    rs_f     = instr_q[25:21];
    rt_f     = instr_q[20:16];
    rd_f     = instr_q[15:11];
    fn_f     = instr_q[5:0];
    imm_sext = {{(W-16){instr_q[15]}}, instr_q[15:0]};
  end

  // Register read with write-first bypass from a concurrent load return; R0 is hardwired to 0.
  always_comb begin
    if (rs_f == 5'd0)                             rs_val = '0;
    else if (ld_wr_en && (ld_wr_addr == rs_f))    rs_val = ld_wr_data;
    else                                          rs_val = rf_q[rs_f];
    if (rt_f == 5'd0)                             rt_val = '0;
    else if (ld_wr_en && (ld_wr_addr == rt_f))    rt_val = ld_wr_data;
    else                                          rt_val = rf_q[rt_f];
  end

  always_comb begin
    // NOTE: every _d starts from its held value (pulses from 0) so no path through this
    // block leaves a variable unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cls_d       = cls_q;
    instr_d     = instr_q;
    opcode_d    = opcode_q;
    func_d      = func_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    ld_req_d    = 1'b0;
    br_taken_d  = 1'b0;
    ld_addr_d   = ld_addr_q;
    ld_rt_d     = ld_rt_q;
    br_offset_d = br_offset_q;
    rf_d        = rf_q;

    if (ld_wr_en && (ld_wr_addr != 5'd0)) rf_d[ld_wr_addr] = ld_wr_data;

    unique case (state_q)
      S_IDLE: begin
        if (in_if.in_valid) begin
          instr_d = in_if.in_instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        if ((op_f == OP_RTYPE) && ((fn_f == FN_ADD) || (fn_f == FN_AND) || (fn_f == FN_SLT))) begin
          cls_d    = C_RTYPE;
          opcode_d = OP_RTYPE;
          func_d   = fn_f;
          a_d      = rs_val;
          b_d      = rt_val;
        end else if (op_f == OP_LW) begin
          cls_d    = C_LW;
          opcode_d = OP_LW;
          func_d   = 6'd0;
          a_d      = rs_val;
          b_d      = imm_sext;
        end else if (op_f == OP_BEQ) begin
          cls_d    = C_BEQ;
          opcode_d = OP_BEQ;
          func_d   = 6'd0;
          a_d      = rs_val;
          b_d      = rt_val;
        end else begin
          cls_d    = C_ILLEGAL;
        end
      end
      S_EXEC: begin
        // Pulses are registered here so they are high for exactly the WB cycle.
        state_d  = S_WB;
        result_d = alu_result;
        done_d   = 1'b1;
        unique case (cls_q)
          C_LW: begin
            ld_req_d  = 1'b1;
            ld_addr_d = alu_result;
            ld_rt_d   = rt_f;
          end
          C_BEQ: begin
            br_taken_d  = alu_zero;
            br_offset_d = {imm_sext[W-3:0], 2'b00};
          end
          C_ILLEGAL: illegal_d = 1'b1;
          default: ;
        endcase
      end
      S_WB: begin
        state_d = S_IDLE;
        // Applied after the load-return write so the WB write wins on an index clash.
        if ((cls_q == C_RTYPE) && (rd_f != 5'd0)) rf_d[rd_f] = result_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_ISSUE_PERF_EN
  always_comb begin
    perf_retired_d = perf_retired_q;
    perf_illegal_d = perf_illegal_q;
    if (done_q)    perf_retired_d = perf_retired_q + 32'd1;
    if (illegal_q) perf_illegal_d = perf_illegal_q + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: state is updated only with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      cls_q       <= C_ILLEGAL;
      instr_q     <= '0;
      opcode_q    <= '0;
      func_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      ld_req_q    <= 1'b0;
      ld_addr_q   <= '0;
      ld_rt_q     <= '0;
      br_taken_q  <= 1'b0;
      br_offset_q <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is built from
      // flops with a reset rather than inferred as a RAM macro without one.
      rf_q        <= '{default: '0};
`ifdef ALU_ISSUE_PERF_EN
      perf_retired_q <= '0;
      perf_illegal_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      instr_q     <= instr_d;
      opcode_q    <= opcode_d;
      func_q      <= func_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      ld_req_q    <= ld_req_d;
      ld_addr_q   <= ld_addr_d;
      ld_rt_q     <= ld_rt_d;
      br_taken_q  <= br_taken_d;
      br_offset_q <= br_offset_d;
      rf_q        <= rf_d;
`ifdef ALU_ISSUE_PERF_EN
      perf_retired_q <= perf_retired_d;
      perf_illegal_q <= perf_illegal_d;
`endif
    end
  end

  assign in_if.in_ready = (state_q == S_IDLE);
  assign alu_opcode     = opcode_q;
  assign alu_func       = func_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign done           = done_q;
  assign illegal        = illegal_q;
  assign ld_req         = ld_req_q;
  assign ld_addr        = ld_addr_q;
  assign ld_rt          = ld_rt_q;
  assign br_taken       = br_taken_q;
  assign br_offset      = br_offset_q;
`ifdef ALU_ISSUE_PERF_EN
  assign perf_retired   = perf_retired_q;
  assign perf_illegal   = perf_illegal_q;
`endif

  // Class pulses only ever accompany done, and at most one of them fires per retirement.
  a_pulse_with_done: assert property (@(posedge clk) disable iff (rst)
    (illegal_q || ld_req_q || br_taken_q) |-> done_q);
  a_pulse_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({illegal_q, ld_req_q, br_taken_q}));

endmodule
